// File: rtl/timing_validity_tracker_pkg.sv
// Shared command codes, timing-class indices and counter helpers for the
// timing validity tracker.
package timing_validity_tracker_pkg;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_PRE    = 3'd1;
    localparam logic [2:0] CMD_ACT    = 3'd2;
    localparam logic [2:0] CMD_CASRD  = 3'd3;
    localparam logic [2:0] CMD_CASRDA = 3'd4;
    localparam logic [2:0] CMD_CASWR  = 3'd5;
    localparam logic [2:0] CMD_CASWRA = 3'd6;

    localparam int CLS_PRE   = 0;
    localparam int CLS_ACT   = 1;
    localparam int CLS_CASRD = 2;
    localparam int CLS_CASWR = 3;

    // Helpers work on a wide word; callers cast to their own counter width.
    localparam int HW = 32;

    function automatic logic [HW-1:0] sat_dec(input logic [HW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [HW-1:0] max2(input logic [HW-1:0] a, input logic [HW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/timing_validity_tracker_faw_window.sv
// Per-rank tFAW sliding window: FAW_DEPTH countdown slots, one claimed per ACT.
module timing_validity_tracker_faw_window
    import timing_validity_tracker_pkg::*;
#(
    parameter int FAW_DEPTH  = 4,
    parameter int TIME_WIDTH = 8,
    parameter int LOOKAHEAD  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  act_issue,
    input  logic [TIME_WIDTH-1:0] t_faw,
    output logic                  faw_open,
    output logic                  faw_viol
);

    localparam logic [TIME_WIDTH-1:0] LA = TIME_WIDTH'(LOOKAHEAD);

    logic [FAW_DEPTH-1:0][TIME_WIDTH-1:0] slot;
    logic [FAW_DEPTH-1:0]                 free;
    logic [FAW_DEPTH-1:0]                 grant;
    logic                                 open;

    // A slot at 1 reaches 0 this cycle, so it can be reclaimed now.
    always_comb begin
        open = 1'b0;
        for (int i = 0; i < FAW_DEPTH; i++) begin
            free[i] = (slot[i] <= TIME_WIDTH'(1));
            open    = open | (slot[i] <= LA);
        end
        grant = free & (~free + FAW_DEPTH'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= '0;
            faw_viol <= 1'b0;
        end else begin
            for (int i = 0; i < FAW_DEPTH; i++) begin
                if (act_issue && grant[i])
                    slot[i] <= t_faw;
                else
                    slot[i] <= TIME_WIDTH'(sat_dec(HW'(slot[i])));
            end
            if (act_issue && (free == '0))
                faw_viol <= 1'b1;
        end
    end

    assign faw_open = open;

endmodule

// File: rtl/timing_validity_tracker.sv
// Per-bank timing countdown counters plus per-rank tFAW windows, producing a
// timing-valid flag for each bank's candidate command.
module timing_validity_tracker
    import timing_validity_tracker_pkg::*;
#(
    parameter int NUM_BNK_TOT    = 8,
    parameter int NUM_RNK_TOT    = 1,
    parameter int CMD_TYPE_WIDTH = 3,
    parameter int PTTRN_WIDTH    = 4,
    parameter int TIME_WIDTH     = 8,
    parameter int NUM_CLS        = 4,
    parameter int FAW_DEPTH      = 4,
    parameter int LOOKAHEAD      = 1,
    parameter int CAS_EN         = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic [NUM_BNK_TOT-1:0][CMD_TYPE_WIDTH-1:0]           cand_cmd,
    input  logic [PTTRN_WIDTH-1:0]                               pattern,
    input  logic [NUM_BNK_TOT-1:0][NUM_CLS-1:0]                  ld_en,
    input  logic [NUM_BNK_TOT-1:0][NUM_CLS-1:0][TIME_WIDTH-1:0]  ld_val,
    input  logic [NUM_RNK_TOT-1:0]                               act_issue,
    input  logic [TIME_WIDTH-1:0]                                t_faw,
    output logic [NUM_BNK_TOT-1:0]                               tv_f,
    output logic [NUM_RNK_TOT-1:0]                               faw_open,
    output logic [NUM_RNK_TOT-1:0]                               faw_viol
);

    localparam int                    BPR    = NUM_BNK_TOT / NUM_RNK_TOT;
    localparam logic [TIME_WIDTH-1:0] LA     = TIME_WIDTH'(LOOKAHEAD);
    localparam bit                    CAS_ON = (CAS_EN != 0);

    logic [NUM_BNK_TOT-1:0][NUM_CLS-1:0][TIME_WIDTH-1:0] cnt;
    logic [NUM_BNK_TOT-1:0][NUM_CLS-1:0]                 cls_ok;
    logic                                                unused_pat;

    assign unused_pat = pattern[0];

    for (genvar r = 0; r < NUM_RNK_TOT; r++) begin : g_rnk
        timing_validity_tracker_faw_window #(
            .FAW_DEPTH (FAW_DEPTH),
            .TIME_WIDTH(TIME_WIDTH),
            .LOOKAHEAD (LOOKAHEAD)
        ) u_faw (
            .clk      (clk),
            .rst_n    (rst_n),
            .act_issue(act_issue[r]),
            .t_faw    (t_faw),
            .faw_open (faw_open[r]),
            .faw_viol (faw_viol[r])
        );
    end

    for (genvar b = 0; b < NUM_BNK_TOT; b++) begin : g_bnk
        for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
            if (!CAS_ON && (c == CLS_CASRD || c == CLS_CASWR)) begin : g_off
                assign cnt[b][c] = '0;
            end else begin : g_on
                logic [TIME_WIDTH-1:0] q;
                // Max-merge: a shorter new constraint never cuts an older one short.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        q <= '0;
                    else if (ld_en[b][c])
                        q <= TIME_WIDTH'(max2(HW'(ld_val[b][c]), sat_dec(HW'(q))));
                    else
                        q <= TIME_WIDTH'(sat_dec(HW'(q)));
                end
                assign cnt[b][c] = q;
            end
            assign cls_ok[b][c] = (cnt[b][c] <= LA);
        end

        logic v;
        always_comb begin
            v = 1'b0;
            case (cand_cmd[b])
                CMD_TYPE_WIDTH'(CMD_PRE):    v = cls_ok[b][CLS_PRE];
                CMD_TYPE_WIDTH'(CMD_ACT):    v = cls_ok[b][CLS_ACT] && faw_open[b / BPR] && !pattern[1];
                CMD_TYPE_WIDTH'(CMD_CASRD),
                CMD_TYPE_WIDTH'(CMD_CASRDA): v = CAS_ON && cls_ok[b][CLS_CASRD] && !pattern[2];
                CMD_TYPE_WIDTH'(CMD_CASWR),
                CMD_TYPE_WIDTH'(CMD_CASWRA): v = CAS_ON && cls_ok[b][CLS_CASWR] && !pattern[3];
                default:                     v = 1'b0;
            endcase
        end
        assign tv_f[b] = v;
    end

endmodule

// File: tb/tb_timing_validity_tracker.sv
// Self-checking bench: reset, table vectors, multi-cycle corner sequences and
// randomized traffic against a deadline-based reference model.
module tb_timing_validity_tracker;
    import timing_validity_tracker_pkg::*;

    localparam int NB = 8, NR = 2, CW = 3, PW = 4, TW = 8, NC = 4, FD = 4, LA = 1;
    localparam int BPR = NB / NR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NB-1:0][CW-1:0]         cand_cmd;
    logic [PW-1:0]                 pattern;
    logic [NB-1:0][NC-1:0]         ld_en;
    logic [NB-1:0][NC-1:0][TW-1:0] ld_val;
    logic [NR-1:0]                 act_issue;
    logic [TW-1:0]                 t_faw;
    logic [NB-1:0]                 tv_f, tv_f_nc;
    logic [NR-1:0]                 faw_open, faw_viol, faw_open_nc, faw_viol_nc;

    timing_validity_tracker #(.NUM_BNK_TOT(NB), .NUM_RNK_TOT(NR), .CMD_TYPE_WIDTH(CW),
        .PTTRN_WIDTH(PW), .TIME_WIDTH(TW), .NUM_CLS(NC), .FAW_DEPTH(FD),
        .LOOKAHEAD(LA), .CAS_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cand_cmd(cand_cmd), .pattern(pattern),
        .ld_en(ld_en), .ld_val(ld_val), .act_issue(act_issue), .t_faw(t_faw),
        .tv_f(tv_f), .faw_open(faw_open), .faw_viol(faw_viol));

    timing_validity_tracker #(.NUM_BNK_TOT(NB), .NUM_RNK_TOT(NR), .CMD_TYPE_WIDTH(CW),
        .PTTRN_WIDTH(PW), .TIME_WIDTH(TW), .NUM_CLS(NC), .FAW_DEPTH(FD),
        .LOOKAHEAD(LA), .CAS_EN(0)) u_nocas (
        .clk(clk), .rst_n(rst_n), .cand_cmd(cand_cmd), .pattern(pattern),
        .ld_en(ld_en), .ld_val(ld_val), .act_issue(act_issue), .t_faw(t_faw),
        .tv_f(tv_f_nc), .faw_open(faw_open_nc), .faw_viol(faw_viol_nc));

    always #5 clk = ~clk;

    int n_run = 0, n_fail = 0;

    // Model: every counter/slot is an absolute cycle deadline; remaining = deadline - now.
    int cyc = 0;
    int exp_t [NB][NC];
    int fdl   [NR][FD];
    bit mviol [NR];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit m_open(input int r);
        for (int s = 0; s < FD; s++)
            if (fdl[r][s] - cyc <= LA) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NB-1:0] m_tv(input bit cas);
        logic [NB-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            case (cand_cmd[b])
                CMD_PRE:    v[b] = (exp_t[b][CLS_PRE] - cyc <= LA);
                CMD_ACT:    v[b] = (exp_t[b][CLS_ACT] - cyc <= LA) && m_open(b / BPR) && !pattern[1];
                CMD_CASRD,
                CMD_CASRDA: v[b] = cas && (exp_t[b][CLS_CASRD] - cyc <= LA) && !pattern[2];
                CMD_CASWR,
                CMD_CASWRA: v[b] = cas && (exp_t[b][CLS_CASWR] - cyc <= LA) && !pattern[3];
                default:    v[b] = 1'b0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [NR-1:0] m_openv();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_open(r);
        return v;
    endfunction

    function automatic logic [NR-1:0] m_violv();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = mviol[r];
        return v;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++) for (int c = 0; c < NC; c++) exp_t[b][c] = 0;
        for (int r = 0; r < NR; r++) begin
            mviol[r] = 1'b0;
            for (int s = 0; s < FD; s++) fdl[r][s] = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk("tv_f", tv_f, m_tv(1'b1));
        chk("tv_f_nocas", tv_f_nc, m_tv(1'b0));
        chk("faw_open", faw_open, m_openv());
        chk("faw_viol", faw_viol, m_violv());
    endtask

    task automatic tick();
        bit found;
        @(posedge clk);
        if (rst_n) begin
            for (int b = 0; b < NB; b++)
                for (int c = 0; c < NC; c++)
                    if (ld_en[b][c] && (cyc + 1 + int'(ld_val[b][c]) > exp_t[b][c]))
                        exp_t[b][c] = cyc + 1 + int'(ld_val[b][c]);
            for (int r = 0; r < NR; r++) begin
                if (act_issue[r]) begin
                    found = 1'b0;
                    for (int s = 0; s < FD; s++)
                        if (!found && (fdl[r][s] - cyc <= 1)) begin
                            fdl[r][s] = cyc + 1 + int'(t_faw);
                            found = 1'b1;
                        end
                    if (!found) mviol[r] = 1'b1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_strobes();
        ld_en = '0;
        act_issue = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        settle();
        chk("rst_viol", faw_viol, 2'b00);
        chk("rst_open", faw_open, 2'b11);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic count_blocked(input int b, output int n);
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            settle();
            if (tv_f[b]) done = 1'b1;
            else n++;
            tick();
        end
    endtask

    typedef struct {
        logic [NB-1:0][CW-1:0] cmd;
        logic [PW-1:0]         pat;
        logic [NB-1:0]         tv;
        logic [NB-1:0]         tv_nc;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        logic [NB-1:0][CW-1:0] mixed;
        int n;

        mixed = {3'd7, CMD_NOP, CMD_CASWRA, CMD_CASWR, CMD_CASRDA, CMD_CASRD, CMD_ACT, CMD_PRE};
        tbl[0]  = '{{NB{CMD_ACT}},    4'b0000, 8'hff, 8'hff};
        tbl[1]  = '{{NB{CMD_ACT}},    4'b0010, 8'h00, 8'h00};
        tbl[2]  = '{{NB{CMD_PRE}},    4'b1111, 8'hff, 8'hff};
        tbl[3]  = '{{NB{CMD_CASWR}},  4'b1000, 8'h00, 8'h00};
        tbl[4]  = '{{NB{CMD_CASWR}},  4'b0000, 8'hff, 8'h00};
        tbl[5]  = '{{NB{CMD_CASRDA}}, 4'b0100, 8'h00, 8'h00};
        tbl[6]  = '{{NB{CMD_CASRDA}}, 4'b1000, 8'hff, 8'h00};
        tbl[7]  = '{{NB{CMD_NOP}},    4'b0000, 8'h00, 8'h00};
        tbl[8]  = '{mixed,            4'b0000, 8'h3f, 8'h03};
        tbl[9]  = '{mixed,            4'b0100, 8'h33, 8'h03};
        tbl[10] = '{mixed,            4'b1010, 8'h0d, 8'h01};

        cand_cmd = {NB{CMD_ACT}};
        pattern = '0;
        ld_val = '0;
        t_faw = 8'd20;
        clear_strobes();
        model_clear();

        // Reset held, then released: nothing changes.
        #2;
        settle();
        chk("rst_tv", tv_f, 8'hff);
        chk("rst_open", faw_open, 2'b11);
        chk("rst_viol", faw_viol, 2'b00);
        tick();
        rst_n = 1'b1;
        settle();
        chk("post_rst_tv", tv_f, 8'hff);
        chk("post_rst_open", faw_open, 2'b11);
        tick();

        for (int i = 0; i < 11; i++) begin
            cand_cmd = tbl[i].cmd;
            pattern = tbl[i].pat;
            settle();
            chk($sformatf("tbl%0d_tv", i), tv_f, tbl[i].tv);
            chk($sformatf("tbl%0d_tv_nocas", i), tv_f_nc, tbl[i].tv_nc);
            tick();
        end

        // Load 5 into bank 3 ACT: blocked for 4 cycles, then valid.
        cand_cmd = {NB{CMD_ACT}};
        pattern = '0;
        ld_en[3][CLS_ACT] = 1'b1;
        ld_val[3][CLS_ACT] = 8'd5;
        settle();
        chk("ld_cycle_tv", tv_f, 8'hff);
        tick();
        clear_strobes();
        for (int k = 1; k <= 6; k++) begin
            settle();
            chk($sformatf("ld_cd%0d", k), tv_f, (k <= 4) ? 8'hf7 : 8'hff);
            tick();
        end

        // Max-merge: counter 6, load 2 -> 5 (4 blocked cycles); then load 9 -> 8 blocked.
        ld_en[0][CLS_ACT] = 1'b1;
        ld_val[0][CLS_ACT] = 8'd6;
        settle();
        tick();
        ld_val[0][CLS_ACT] = 8'd2;
        settle();
        tick();
        clear_strobes();
        count_blocked(0, n);
        chk("merge_keep_longer", n, 4);
        ld_en[0][CLS_ACT] = 1'b1;
        ld_val[0][CLS_ACT] = 8'd9;
        settle();
        tick();
        clear_strobes();
        count_blocked(0, n);
        chk("merge_take_longer", n, 8);

        // tFAW: ACTs at 0,2,4,6 fill rank 0; fifth at 8 violates.
        for (int k = 0; k <= 22; k++) begin
            act_issue = ((k % 2 == 0) && (k <= 8)) ? 2'b01 : 2'b00;
            settle();
            if (k == 6)  chk("faw_open_last", faw_open, 2'b11);
            if (k == 7)  begin chk("faw_closed", faw_open, 2'b10); chk("faw_tv", tv_f, 8'hf0); end
            if (k == 8)  chk("viol_before", faw_viol, 2'b00);
            if (k == 9)  chk("viol_set", faw_viol, 2'b01);
            if (k == 19) chk("faw_still_closed", faw_open, 2'b10);
            if (k == 20) begin chk("faw_reopen", faw_open, 2'b11); chk("faw_reopen_tv", tv_f, 8'hff); end
            if (k == 22) chk("viol_sticky", faw_viol, 2'b01);
            tick();
        end
        clear_strobes();
        do_reset();
        settle();
        chk("viol_cleared", faw_viol, 2'b00);
        tick();

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                t_faw = TW'($urandom_range(0, 30));
                do_reset();
            end
            for (int b = 0; b < NB; b++) begin
                cand_cmd[b] = CW'($urandom_range(0, 7));
                for (int c = 0; c < NC; c++) begin
                    ld_en[b][c] = ($urandom_range(0, 9) == 0);
                    ld_val[b][c] = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, 40))
                                                               : TW'($urandom_range(0, 12));
                end
            end
            pattern = PW'($urandom_range(0, 15));
            for (int r = 0; r < NR; r++) act_issue[r] = ($urandom_range(0, 3) == 0);
            settle();
            tick();
        end
        clear_strobes();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
